// File: rtl/prog_loader.sv
// prog_loader
//   Loads a framed byte stream into the 16-bit core's instruction memory.
//   Frame: LEN_HI, LEN_LO (word count N, big-endian), 2N data bytes (high
//   byte of each word first), then one checksum byte equal to the XOR of
//   every preceding byte of the frame. Words are written at byte addresses
//   BASE_ADDR, BASE_ADDR+2, ... to match the core's pc+2 fetch sequence.
//
// Parameters
//   BASE_ADDR  byte address of the first instruction written
//   MEM_WORDS  instruction memory depth in words (largest legal N)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_start  one-cycle request to start a load (IDLE/DONE/ERR only)
//   in_valid    stream byte valid
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   imem_we     one-cycle write strobe per assembled word
//   imem_addr   write byte address (held until the next write)
//   imem_wdata  write data word (held until the next write)
//   core_hold   keeps the core stalled while loading or after an error
//   done        level: last load finished with a good checksum
//   err         level: last load aborted (oversize count or bad checksum)
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    DONE,
    ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  hi_byte_reg, hi_byte_next;   // LEN_HI, then each data high byte
  logic [15:0] len_reg, len_next;
  logic [15:0] idx_reg, idx_next;
  logic [7:0]  xor_reg, xor_next;
  logic        we_reg, we_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;

  logic        hs;
  logic [15:0] len_rx;
  logic [15:0] idx_inc;

  assign in_ready = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                    (state_reg == S_DATA_HI) || (state_reg == S_DATA_LO) ||
                    (state_reg == S_CHECK);
  assign hs       = in_valid & in_ready;
  assign len_rx   = {hi_byte_reg, in_data};
  assign idx_inc  = idx_reg + 16'd1;

  always_comb begin
    state_next   = state_reg;
    hi_byte_next = hi_byte_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    xor_next     = xor_reg;
    we_next      = 1'b0;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          state_next = S_LEN_HI;
          idx_next   = 16'd0;
          xor_next   = 8'd0;
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          hi_byte_next = in_data;
          xor_next     = xor_reg ^ in_data;
          state_next   = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          xor_next = xor_reg ^ in_data;
          len_next = len_rx;
          if (32'(len_rx) > MEM_WORDS) begin
            state_next = ERR;
          end else if (len_rx == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (hs) begin
          hi_byte_next = in_data;
          xor_next     = xor_reg ^ in_data;
          state_next   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (hs) begin
          xor_next   = xor_reg ^ in_data;
          we_next    = 1'b1;
          wdata_next = {hi_byte_reg, in_data};
          // Sum intentionally truncated: loads near the top of the map wrap.
          addr_next  = BASE_ADDR + {idx_reg[14:0], 1'b0};
          idx_next   = idx_inc;
          state_next = (idx_inc == len_reg) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (hs) begin
          state_next = (in_data == xor_reg) ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Asynchronous clear makes imem_we drop the instant reset asserts, so an
  // in-flight word is discarded rather than written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      hi_byte_reg <= 8'd0;
      len_reg     <= 16'd0;
      idx_reg     <= 16'd0;
      xor_reg     <= 8'd0;
      we_reg      <= 1'b0;
      addr_reg    <= 16'd0;
      wdata_reg   <= 16'd0;
    end else begin
      state_reg   <= state_next;
      hi_byte_reg <= hi_byte_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      xor_reg     <= xor_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign core_hold  = in_ready || (state_reg == ERR);
  assign done       = (state_reg == DONE);
  assign err        = (state_reg == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Drives framed byte streams into two loaders sharing the same inputs: one
//   at BASE_ADDR=0x0000 and one at 0xFFFE (address wrap). Expected writes are
//   queued per instance as data-low bytes are driven; a monitor pops and
//   compares on every imem_we.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        rdy0, we0, hold0, done0, err0;
  logic [15:0] addr0, wdata0;
  logic        rdy1, we1, hold1, done1, err1;
  logic [15:0] addr1, wdata1;

  int errors = 0;
  int checks = 0;
  int we_cnt0 = 0;
  int we_cnt1 = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [15:0] words_q[$];
  logic [31:0] e0, e1;

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(16'h0000), .MEM_WORDS(128)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy0), .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wdata0), .core_hold(hold0), .done(done0), .err(err0)
  );

  prog_loader #(.BASE_ADDR(16'hFFFE), .MEM_WORDS(128)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wdata1), .core_hold(hold1), .done(done1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (we0) begin
      we_cnt0++;
      if (exp_q0.size() == 0) check("we0_unexpected", {addr0, wdata0}, 32'hxxxxxxxx);
      else begin
        e0 = exp_q0.pop_front();
        check("wr0", {addr0, wdata0}, e0);
      end
    end
    if (we1) begin
      we_cnt1++;
      if (exp_q1.size() == 0) check("we1_unexpected", {addr1, wdata1}, 32'hxxxxxxxx);
      else begin
        e1 = exp_q1.pop_front();
        check("wr1", {addr1, wdata1}, e1);
      end
    end
  end

  task automatic push_exp(input int i, input logic [15:0] w);
    logic [15:0] a0, a1;
    a0 = 16'h0000 + 16'(2 * i);
    a1 = 16'hFFFE + 16'(2 * i);
    exp_q0.push_back({a0, w});
    exp_q1.push_back({a1, w});
  endtask

  // Presents one byte and returns at posedge+1 after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit hs;
    int n;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      hs = rdy0;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 50);
    if (!hs) check("hs_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("hold_rise", {31'd0, hold0}, 32'd1);
  endtask

  // Sends a complete frame for words_q; the scoreboard learns each word just
  // before its low byte goes out.
  task automatic send_frame(input bit bad, input bit gaps, input bit mid_start);
    logic [15:0] n;
    logic [7:0]  x;
    n = 16'(words_q.size());
    x = n[15:8] ^ n[7:0];
    we_cnt0 = 0;
    we_cnt1 = 0;
    pulse_start();
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    for (int i = 0; i < words_q.size(); i++) begin
      if (mid_start && i == 0) load_start = 1'b1;
      send_byte(words_q[i][15:8], gaps);
      load_start = 1'b0;
      push_exp(i, words_q[i]);
      send_byte(words_q[i][7:0], gaps);
      x = x ^ words_q[i][15:8] ^ words_q[i][7:0];
    end
    send_byte(bad ? (x ^ 8'h01) : x, gaps);
    check("done0", {31'd0, done0}, {31'd0, !bad});
    check("done1", {31'd0, done1}, {31'd0, !bad});
    check("err0", {31'd0, err0}, {31'd0, bad});
    check("hold0", {31'd0, hold0}, {31'd0, bad});
    check("we_count0", we_cnt0, words_q.size());
    check("we_count1", we_cnt1, words_q.size());
    check("queue_empty", exp_q0.size() + exp_q1.size(), 32'd0);
  endtask

  task automatic basic_words();
    words_q.delete();
    words_q.push_back(16'h1234);
    words_q.push_back(16'hABCD);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs0", {rdy0, we0, hold0, done0, err0, addr0, wdata0}, 37'd0);
    check("rst_outs1", {rdy1, we1, hold1, done1, err1, addr1, wdata1}, 37'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", {27'd0, rdy0, we0, hold0, done0, err0}, 32'd0);

    // Basic load, no gaps: last write coincides with the checksum byte
    basic_words();
    send_frame(1'b0, 1'b0, 1'b0);

    // Bad checksum: words still written, err latched with hold
    send_frame(1'b1, 1'b0, 1'b0);
    // New load_start clears err; continue straight into an oversize count
    we_cnt0 = 0;
    pulse_start();
    check("err_clear", {31'd0, err0}, 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h81, 1'b0);
    check("oversize_err", {31'd0, err0}, 32'd1);
    check("oversize_rdy", {31'd0, rdy0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("oversize_no_we", we_cnt0, 32'd0);

    // Exactly MEM_WORDS is legal: sequence of 128 words in the 0x00.. map
    words_q.delete();
    for (int i = 0; i < 128; i++) words_q.push_back(16'($urandom));
    send_frame(1'b0, 1'b0, 1'b0);

    // Random gaps on in_valid with garbage data during the gaps
    basic_words();
    for (int r = 0; r < 3; r++) send_frame(1'b0, 1'b1, 1'b0);

    // load_start mid-load is ignored
    basic_words();
    send_frame(1'b0, 1'b0, 1'b1);

    // Empty frame 00 00 00
    words_q.delete();
    send_frame(1'b0, 1'b0, 1'b0);

    // Reset mid-load after byte AB
    we_cnt0 = 0;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    push_exp(0, 16'h1234);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs0", {rdy0, we0, hold0, done0, err0, addr0, wdata0}, 37'd0);
    check("midrst_outs1", {rdy1, we1, hold1, done1, err1, addr1, wdata1}, 37'd0);
    check("midrst_we_count", we_cnt0, 32'd1);
    check("midrst_queue", exp_q0.size() + exp_q1.size(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh load after reset
    basic_words();
    send_frame(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that fills the instruction memory consumed by the single-cycle 16-bit core. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them at consecutive byte addresses stepping by 2, matching the core's `pc + 2` fetch sequence. It checks a trailing XOR checksum and holds the core (`core_hold`) for the whole load.

## Interface
- `BASE_ADDR`, default 16'h0000: byte address of the first written instruction.
- `MEM_WORDS`, default 128: instruction memory depth in 16-bit words; the maximum legal word count.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid & in_ready` at a rising edge.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  16  write byte address.
- `imem_wdata`  out  16  write data word.
- `core_hold`  out  1  hold the core's PC and writes while loading.
- `done`  out  1  load completed with a good checksum.
- `err`  out  1  load aborted: oversize count or checksum mismatch.

## Operation
- Frame: `LEN_HI`, `LEN_LO` (word count N, 16-bit big-endian), then 2N data bytes (high byte of each word first), then one checksum byte.
- Checksum: XOR of every byte from `LEN_HI` through the last data byte. The checksum byte itself is excluded.
- States and transitions:
  - IDLE → S_LEN_HI on `load_start`.
  - S_LEN_HI → S_LEN_LO on handshake.
  - S_LEN_LO:
    - → ERR if N > `MEM_WORDS`.
    - → S_CHECK if N == 0.
    - → S_DATA_HI otherwise.
  - S_DATA_HI → S_DATA_LO on handshake.
  - S_DATA_LO:
    - → S_DATA_HI on handshake if words remain.
    - → S_CHECK on handshake if this was the last word.
  - S_CHECK: → DONE if the received byte equals the running XOR; → ERR otherwise.
  - DONE and ERR: stay until `load_start`, then → S_LEN_HI, clearing the word index, running XOR, `done` and `err`.
- `load_start` in any S_* state is ignored.
- `in_ready` = 1 only in the S_* states; it is combinational from state.
- `in_valid` without `in_ready` is ignored; no byte is consumed.
- Word write:
  - On the S_DATA_LO handshake, register `imem_wdata = {hi_byte, in_data}` and `imem_addr = BASE_ADDR + {idx[14:0], 1'b0}`, with the sum truncated to 16 bits (wraps past 16'hFFFF).
  - Increment `idx` and pulse `imem_we` for exactly one cycle.
- Partially written memory is never rolled back on ERR or reset.
- `core_hold` = 1 in the S_* states and in ERR; 0 in IDLE and DONE.
- `done` = 1 only in DONE; `err` = 1 only in ERR. Both are levels.

## Timing
- Reset (async assert, sync release) → IDLE. All outputs are 0 during and after reset: `in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `core_hold`, `done`, `err`.
- Reset mid-load: IDLE immediately. `imem_we` drops without waiting for a clock edge; any in-flight word is lost.
- `core_hold` rises the cycle after `load_start` is sampled.
- `imem_we` is high the cycle after the `DATA_LO` handshake. `imem_addr` and `imem_wdata` are stable for that cycle and hold their values until the next write.
- Back-to-back: a word is written at most every 2 cycles. The loader sustains 1 byte/cycle with no stall.
- Last word: its `imem_we` cycle coincides with the first S_CHECK cycle. A checksum byte presented in that same cycle is accepted.
- `done`/`err` rise the cycle after the checksum handshake. For an oversize count, `err` rises the cycle after the `LEN_LO` handshake.
- N == 0: no `imem_we` pulses. Expected checksum = `LEN_HI ^ LEN_LO` = 0x00.

## Test plan
- Basic load, BASE_ADDR=0: `load_start`, then bytes 00 02 12 34 AB CD 42, 1 byte/cycle.
  - Writes (0x0000, 0x1234) and (0x0002, 0xABCD), one cycle each.
  - `done`=1, `core_hold`=0, `err`=0.
- Bad checksum: same stream ending in 0x43.
  - Both words are written.
  - `err`=1, `done`=0, `core_hold` stays 1.
  - A new `load_start` clears `err`.
- Oversize: with MEM_WORDS=128, send 00 81.
  - `err`=1 the cycle after `LEN_LO`; `in_ready`=0 afterwards; no `imem_we`.
- Backpressure and gaps: drop `in_valid` randomly in the basic stream.
  - Identical writes and `done`. `imem_we` count is 2.
  - No byte is consumed while `in_valid`=0.
- Reset mid-load: assert `rst_n`=0 after byte AB of the basic stream.
  - All outputs go to 0 immediately.
  - Only the 0x1234 write has occurred.
  - A fresh load then completes normally.
- Edge cases:
  - Empty frame 00 00 00 → `done`=1 with no writes.
  - BASE_ADDR=16'hFFFE with N=2 → writes at 0xFFFE then 0x0000.
  - `load_start` asserted mid-load is ignored.
